// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decode path: scan-code constants,
// frame-receiver state encoding and the set-2 scan-code to ASCII lookup.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [6:0] IDLE_ASCII_DEF = 7'd32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Returns {mapped, ascii[6:0]}; mapped=0 means the code is ignored.
    function automatic logic [7:0] scancode_to_ascii(input logic [7:0] sc);
        logic [7:0] r;
        r = 8'h00;
        case (sc)
            8'h1C: r = {1'b1, 7'h41}; // A
            8'h32: r = {1'b1, 7'h42}; // B
            8'h21: r = {1'b1, 7'h43}; // C
            8'h23: r = {1'b1, 7'h44}; // D
            8'h24: r = {1'b1, 7'h45}; // E
            8'h2B: r = {1'b1, 7'h46}; // F
            8'h34: r = {1'b1, 7'h47}; // G
            8'h33: r = {1'b1, 7'h48}; // H
            8'h43: r = {1'b1, 7'h49}; // I
            8'h3B: r = {1'b1, 7'h4A}; // J
            8'h42: r = {1'b1, 7'h4B}; // K
            8'h4B: r = {1'b1, 7'h4C}; // L
            8'h3A: r = {1'b1, 7'h4D}; // M
            8'h31: r = {1'b1, 7'h4E}; // N
            8'h44: r = {1'b1, 7'h4F}; // O
            8'h4D: r = {1'b1, 7'h50}; // P
            8'h15: r = {1'b1, 7'h51}; // Q
            8'h2D: r = {1'b1, 7'h52}; // R
            8'h1B: r = {1'b1, 7'h53}; // S
            8'h2C: r = {1'b1, 7'h54}; // T
            8'h3C: r = {1'b1, 7'h55}; // U
            8'h2A: r = {1'b1, 7'h56}; // V
            8'h1D: r = {1'b1, 7'h57}; // W
            8'h22: r = {1'b1, 7'h58}; // X
            8'h35: r = {1'b1, 7'h59}; // Y
            8'h1A: r = {1'b1, 7'h5A}; // Z
            8'h45: r = {1'b1, 7'h30}; // 0
            8'h16: r = {1'b1, 7'h31}; // 1
            8'h1E: r = {1'b1, 7'h32}; // 2
            8'h26: r = {1'b1, 7'h33}; // 3
            8'h25: r = {1'b1, 7'h34}; // 4
            8'h2E: r = {1'b1, 7'h35}; // 5
            8'h36: r = {1'b1, 7'h36}; // 6
            8'h3D: r = {1'b1, 7'h37}; // 7
            8'h3E: r = {1'b1, 7'h38}; // 8
            8'h46: r = {1'b1, 7'h39}; // 9
            8'h29: r = {1'b1, 7'h20}; // space
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw PS/2 lines, samples data on
// falling ps2_clk edges and assembles 11-bit frames (start, 8 data LSB first,
// odd parity, stop). Abandons a frame if the line stalls for TIMEOUT_CYCLES.
// Ports:
//   clk, resetn        system clock, async active-low reset
//   ps2_clk, ps2_dat   raw asynchronous PS/2 lines
//   rx_byte            last good byte received
//   byte_valid         one-cycle pulse when rx_byte is updated
//   err                one-cycle pulse on bad start/parity/stop or timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta, clk_sync, clk_prev;
    logic          dat_meta, dat_sync;
    logic          fall_c;

    frame_state_t  state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          par_bit, par_bit_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [7:0]    rx_byte_next;
    logic          byte_valid_next, err_next;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign fall_c = clk_prev & ~clk_sync;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            par_bit    <= par_bit_next;
            tcnt       <= tcnt_next;
            rx_byte    <= rx_byte_next;
            byte_valid <= byte_valid_next;
            err        <= err_next;
        end
    end

    // Frame sequencing; an edge always takes priority over the timeout.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift;
        par_bit_next    = par_bit;
        tcnt_next       = tcnt;
        rx_byte_next    = rx_byte;
        byte_valid_next = 1'b0;
        err_next        = 1'b0;

        if (fall_c) begin
            tcnt_next = '0;
            case (state)
                ST_IDLE: begin
                    if (!dat_sync) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_next = {dat_sync, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_bit_next = dat_sync;
                    state_next   = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (dat_sync && (^{shift, par_bit})) begin
                        rx_byte_next    = shift;
                        byte_valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next = ST_IDLE;
                tcnt_next  = '0;
                err_next   = 1'b1;
            end else begin
                tcnt_next = tcnt + TW'(1);
            end
        end else begin
            tcnt_next = '0;
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard front end: turns set-2 make/break scan-code sequences into a
// held 7-bit ASCII code that changes once per press and once per release.
// Ports:
//   clk, resetn        system clock, async active-low reset
//   ps2_clk, ps2_dat   raw asynchronous PS/2 lines
//   ascii              held key's ASCII code, or IDLE_ASCII when none held
//   ascii_valid        one-cycle pulse whenever ascii changes
//   key_held           high while a mapped key is held
//   frame_err          one-cycle pulse on any framing error or timeout
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [6:0]  IDLE_ASCII     = IDLE_ASCII_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [6:0] ascii,
    output logic       ascii_valid,
    output logic       key_held,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic       ext, ext_next;
    logic       brk, brk_next;
    logic [7:0] held_code, held_code_next;
    logic [6:0] ascii_next;
    logic       ascii_valid_next;
    logic       key_held_next;
    logic [7:0] map_c;
    logic       same_key_c;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .err       (rx_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            held_code   <= 8'h00;
            ascii       <= IDLE_ASCII;
            ascii_valid <= 1'b0;
            key_held    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            ext         <= ext_next;
            brk         <= brk_next;
            held_code   <= held_code_next;
            ascii       <= ascii_next;
            ascii_valid <= ascii_valid_next;
            key_held    <= key_held_next;
            frame_err   <= rx_err;
        end
    end

    // Scan-code layer: prefix flags, make/break against the held key.
    always_comb begin
        ext_next         = ext;
        brk_next         = brk;
        held_code_next   = held_code;
        ascii_next       = ascii;
        ascii_valid_next = 1'b0;
        key_held_next    = key_held;
        map_c            = scancode_to_ascii(rx_byte);
        same_key_c       = key_held && (held_code == rx_byte);

        if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_next = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                // Extended keys are unsupported, so anything after E0 is dropped.
                if (!ext && map_c[7]) begin
                    if (brk) begin
                        if (same_key_c) begin
                            ascii_next       = IDLE_ASCII;
                            key_held_next    = 1'b0;
                            ascii_valid_next = (ascii != IDLE_ASCII);
                        end
                    end else if (!same_key_c) begin
                        ascii_next       = map_c[6:0];
                        key_held_next    = 1'b1;
                        held_code_next   = rx_byte;
                        ascii_valid_next = (ascii != map_c[6:0]);
                    end
                end
            end
        end
    end

endmodule
